// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic-light lamp driver and its safety monitor:
// light codes, lamp patterns, fault codes, monitor states and helper functions.
package traffic_light_pkg;

  localparam logic [1:0] LT_RED     = 2'b00;
  localparam logic [1:0] LT_YELLOW  = 2'b01;
  localparam logic [1:0] LT_GREEN   = 2'b10;
  localparam logic [1:0] LT_ILLEGAL = 2'b11;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_CODE     = 2'b01,
    FLT_CONFLICT = 2'b10,
    FLT_SEQ      = 2'b11
  } fault_code_t;

  typedef enum logic [2:0] {
    INIT,
    NORMAL,
    FLASH_ON,
    FLASH_OFF,
    RECOVER
  } mon_state_t;

  // A direction may hold its colour or advance G->Y->R->G; anything else is a skip.
  function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
    legal_step = (prev == cur) ||
                 (prev == LT_GREEN  && cur == LT_YELLOW) ||
                 (prev == LT_YELLOW && cur == LT_RED) ||
                 (prev == LT_RED    && cur == LT_GREEN);
  endfunction

  // Light code to one-hot lamp pattern; the illegal code falls back to red.
  function automatic logic [2:0] decode_lamp(input logic [1:0] code);
    case (code)
      LT_RED:    decode_lamp = LAMP_R;
      LT_YELLOW: decode_lamp = LAMP_Y;
      LT_GREEN:  decode_lamp = LAMP_G;
      default:   decode_lamp = LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/light_monitor_driver_if.sv
// Bus between the sequencer side and the lamp driver.
// Optional macro FAULT_COUNT_EN adds the fault_cnt signal.
interface light_monitor_driver_if;
  import traffic_light_pkg::*;

  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       fault_clr;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       fault;
  logic [1:0] fault_code;
`ifdef FAULT_COUNT_EN
  logic [7:0] fault_cnt;
`endif

  modport master (
    output ns_light, ew_light, fault_clr,
    input  ns_lamp, ew_lamp, fault, fault_code
`ifdef FAULT_COUNT_EN
    , input fault_cnt
`endif
  );

  modport slave (
    input  ns_light, ew_light, fault_clr,
    output ns_lamp, ew_lamp, fault, fault_code
`ifdef FAULT_COUNT_EN
    , output fault_cnt
`endif
  );

endinterface

// File: rtl/blink_timer.sv
// Restartable cycle timer: done is high during the Nth cycle after a restart,
// where N is given by len. Shared by the flash half-period and the recovery wait.
module blink_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
  input  logic [W-1:0] len,
  output logic         done
);

  logic [W-1:0] cnt;

  // Count elapsed cycles, returning to zero on restart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == len - 1'b1);

endmodule

// File: rtl/light_monitor_driver.sv
// Lamp driver with safety monitor for the traffic-light sequencer output.
// Two-stage pipeline (sample, lamp). Any illegal code, conflicting non-red or
// phase skip latches a fault code and forces flashing red until an operator
// clear and a timed all-red recovery. BLINK_HALF must be at least 1.
// Optional macro FAULT_COUNT_EN adds a saturating count of fault entries.
module light_monitor_driver
  import traffic_light_pkg::*;
#(
  parameter int BLINK_HALF = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  light_monitor_driver_if.slave bus
);

  localparam int TW = $clog2(2 * BLINK_HALF) + 1;
  localparam logic [TW-1:0] HALF_LEN = TW'(BLINK_HALF);
  localparam logic [TW-1:0] REC_LEN  = TW'(2 * BLINK_HALF);

  logic [1:0]  ns_q, ew_q, ns_p, ew_p;
  mon_state_t  state;
  logic        prev_valid;
  fault_code_t chk;
  logic        in_flash;
  logic        tmr_restart;
  logic        tmr_done;
  logic [TW-1:0] tmr_len;

  // Stage 1: sample the incoming codes and keep the previous sample for step checks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ns_q <= LT_RED;
      ew_q <= LT_RED;
      ns_p <= LT_RED;
      ew_p <= LT_RED;
    end else begin
      ns_q <= bus.ns_light;
      ew_q <= bus.ew_light;
      ns_p <= ns_q;
      ew_p <= ew_q;
    end
  end

  // Safety checks on the sampled codes, highest-priority fault wins.
  always_comb begin
    chk = FLT_NONE;
    if (ns_q == LT_ILLEGAL || ew_q == LT_ILLEGAL) begin
      chk = FLT_CODE;
    end else if (ns_q != LT_RED && ew_q != LT_RED) begin
      chk = FLT_CONFLICT;
    end else if (prev_valid && (!legal_step(ns_p, ns_q) || !legal_step(ew_p, ew_q))) begin
      chk = FLT_SEQ;
    end
  end

  assign in_flash    = (state == FLASH_ON) || (state == FLASH_OFF);
  assign tmr_len     = (state == RECOVER) ? REC_LEN : HALF_LEN;
  // The timer is held at zero outside timed states and restarts on every timed transition.
  assign tmr_restart = !(in_flash || state == RECOVER) || tmr_done || (in_flash && bus.fault_clr);

  blink_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (tmr_restart),
    .len     (tmr_len),
    .done    (tmr_done)
  );

  // Monitor FSM with registered lamps, fault flag and latched fault code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= INIT;
      prev_valid     <= 1'b0;
      bus.ns_lamp    <= LAMP_R;
      bus.ew_lamp    <= LAMP_R;
      bus.fault      <= 1'b0;
      bus.fault_code <= FLT_NONE;
    end else begin
      case (state)
        INIT: begin
          state       <= NORMAL;
          prev_valid  <= 1'b0;
          bus.ns_lamp <= LAMP_R;
          bus.ew_lamp <= LAMP_R;
        end
        NORMAL: begin
          if (chk != FLT_NONE) begin
            state          <= FLASH_ON;
            bus.fault      <= 1'b1;
            bus.fault_code <= chk;
            bus.ns_lamp    <= LAMP_R;
            bus.ew_lamp    <= LAMP_R;
          end else begin
            prev_valid  <= 1'b1;
            bus.ns_lamp <= decode_lamp(ns_q);
            bus.ew_lamp <= decode_lamp(ew_q);
          end
        end
        FLASH_ON: begin
          if (bus.fault_clr) begin
            state       <= RECOVER;
            bus.fault   <= 1'b0;
            bus.ns_lamp <= LAMP_R;
            bus.ew_lamp <= LAMP_R;
          end else if (tmr_done) begin
            state       <= FLASH_OFF;
            bus.ns_lamp <= LAMP_OFF;
            bus.ew_lamp <= LAMP_OFF;
          end
        end
        FLASH_OFF: begin
          if (bus.fault_clr) begin
            state       <= RECOVER;
            bus.fault   <= 1'b0;
            bus.ns_lamp <= LAMP_R;
            bus.ew_lamp <= LAMP_R;
          end else if (tmr_done) begin
            state       <= FLASH_ON;
            bus.ns_lamp <= LAMP_R;
            bus.ew_lamp <= LAMP_R;
          end
        end
        RECOVER: begin
          bus.ns_lamp <= LAMP_R;
          bus.ew_lamp <= LAMP_R;
          if (tmr_done) begin
            state          <= NORMAL;
            prev_valid     <= 1'b0;
            bus.fault_code <= FLT_NONE;
          end
        end
        default: begin
          state       <= INIT;
          bus.ns_lamp <= LAMP_R;
          bus.ew_lamp <= LAMP_R;
        end
      endcase
    end
  end

`ifdef FAULT_COUNT_EN
  // Count NORMAL to FLASH_ON entries, saturating; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.fault_cnt <= 8'd0;
    end else if (state == NORMAL && chk != FLT_NONE && bus.fault_cnt != 8'hFF) begin
      bus.fault_cnt <= bus.fault_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_light_monitor_driver.sv
// Scoreboard bench for light_monitor_driver: the driver pushes the hand-derived
// output expected after each clock edge, a monitor pops and compares.
// With FAULT_COUNT_EN defined the fault_cnt output is compared as well.
module tb_light_monitor_driver;
  import traffic_light_pkg::*;

  localparam int BLINK_HALF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  light_monitor_driver_if bus();

  light_monitor_driver #(.BLINK_HALF(BLINK_HALF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         phase;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       flt;
    logic [1:0] code;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int phase = 0;
  int exp_cnt = 0;
  logic [1:0] pat_ns [4];
  logic [1:0] pat_ew [4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string phaseName(input int p);
    case (p)
      0: return "reset";
      1: return "normal";
      2: return "conflict";
      3: return "flash";
      4: return "recover";
      5: return "seqskip";
      6: return "midreset";
      7: return "priority";
      8: return "faultcnt";
      default: return "other";
    endcase
  endfunction

  function automatic logic [2:0] dec(input logic [1:0] c);
    case (c)
      2'b00: return 3'b100;
      2'b01: return 3'b010;
      2'b10: return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] flashLamp(input int m);
    return ((m / BLINK_HALF) % 2 == 0) ? 3'b100 : 3'b000;
  endfunction

  task automatic checkOutput(input exp_t e);
    logic ok;
    ok = (bus.ns_lamp === e.ns) && (bus.ew_lamp === e.ew) &&
         (bus.fault === e.flt) && (bus.fault_code === e.code) && (e.cyc == cyc);
`ifdef FAULT_COUNT_EN
    ok = ok && (int'(bus.fault_cnt) == e.cnt);
`endif
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL %s cyc %0d: got ns=%b ew=%b fault=%b code=%b, required ns=%b ew=%b fault=%b code=%b (due cyc %0d)",
               phaseName(e.phase), cyc, bus.ns_lamp, bus.ew_lamp, bus.fault, bus.fault_code,
               e.ns, e.ew, e.flt, e.code, e.cyc);
`ifdef FAULT_COUNT_EN
      $display("[TB] FAIL %s fault_cnt: got %0d, required %0d", phaseName(e.phase), bus.fault_cnt, e.cnt);
`endif
    end
  endtask

  // Monitor: compare every expectation that has come due.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checkOutput(e);
    end
  end

  // Drive one cycle of inputs and queue the output expected after the next edge.
  task automatic applyStimulus(input logic r, input logic [1:0] ns, input logic [1:0] ew,
                               input logic clr, input logic [2:0] ens, input logic [2:0] eew,
                               input logic ef, input logic [1:0] ecode);
    exp_t e;
    @(negedge clk);
    rst_n         = r;
    bus.ns_light  = ns;
    bus.ew_light  = ew;
    bus.fault_clr = clr;
    e.cyc   = cyc + 1;
    e.phase = phase;
    e.ns    = ens;
    e.ew    = eew;
    e.flt   = ef;
    e.code  = ecode;
    e.cnt   = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic bumpCount();
    exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
  endtask

  // Regular sequencer stream starting right after reset (first edge is INIT).
  task automatic runStream(input int n);
    logic [1:0] lns, lew;
    lns = 2'b00;
    lew = 2'b00;
    for (int i = 0; i < n; i++) begin
      if (i == 0)
        applyStimulus(1'b1, pat_ns[0], pat_ew[0], 1'b0, 3'b100, 3'b100, 1'b0, 2'b00);
      else
        applyStimulus(1'b1, pat_ns[i % 4], pat_ew[i % 4], (i % 5 == 3), dec(lns), dec(lew), 1'b0, 2'b00);
      lns = pat_ns[i % 4];
      lew = pat_ew[i % 4];
    end
  endtask

  // Clear while flashing, 2*BLINK_HALF cycles of red, then one NORMAL cycle of 00/00.
  task automatic recoverSeq(input logic [1:0] code);
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b1, 3'b100, 3'b100, 1'b0, code);
    for (int r = 1; r < 2 * BLINK_HALF; r++)
      applyStimulus(1'b1, 2'b00, 2'b00, r[0], 3'b100, 3'b100, 1'b0, code);
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00);
  endtask

  // From NORMAL with last input 00/00: inject a pattern, see the fault, then recover.
  task automatic faultAndRecover(input logic [1:0] ns, input logic [1:0] ew, input logic [1:0] code);
    applyStimulus(1'b1, ns, ew, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00);
    bumpCount();
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 3'b100, 3'b100, 1'b1, code);
    recoverSeq(code);
  endtask

  initial begin
    pat_ns = '{2'b10, 2'b01, 2'b00, 2'b00};
    pat_ew = '{2'b00, 2'b00, 2'b10, 2'b01};
    bus.ns_light  = 2'b00;
    bus.ew_light  = 2'b00;
    bus.fault_clr = 1'b0;

    phase = 0;
    exp_cnt = 0;
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 3'b100, 3'b100, 1'b0, 2'b00);

    phase = 1;
    runStream(32);
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 3'b100, 3'b010, 1'b0, 2'b00);

    phase = 2;
    applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00);
    bumpCount();
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 3'b100, 3'b100, 1'b1, 2'b10);

    phase = 3;
    for (int m = 1; m < 22; m++)
      applyStimulus(1'b1, 2'b11, 2'b11, 1'b0, flashLamp(m), flashLamp(m), 1'b1, 2'b10);

    phase = 4;
    applyStimulus(1'b1, 2'b11, 2'b11, 1'b1, 3'b100, 3'b100, 1'b0, 2'b10);
    for (int r = 1; r < 7; r++)
      applyStimulus(1'b1, 2'b11, 2'b11, r[0], 3'b100, 3'b100, 1'b0, 2'b10);
    applyStimulus(1'b1, 2'b00, 2'b01, 1'b1, 3'b100, 3'b100, 1'b0, 2'b10);
    applyStimulus(1'b1, 2'b00, 2'b10, 1'b1, 3'b100, 3'b100, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b00, 2'b01, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 3'b100, 3'b010, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00);

    phase = 5;
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00);
    bumpCount();
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 3'b100, 3'b100, 1'b1, 2'b11);
    for (int m = 1; m < 9; m++)
      applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, flashLamp(m), flashLamp(m), 1'b1, 2'b11);

    phase = 6;
    exp_cnt = 0;
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00);
    runStream(8);

    phase = 7;
    applyStimulus(1'b1, 2'b10, 2'b11, 1'b0, 3'b100, 3'b010, 1'b0, 2'b00);
    bumpCount();
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 3'b100, 3'b100, 1'b1, 2'b01);
    for (int m = 1; m < 6; m++)
      applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, flashLamp(m), flashLamp(m), 1'b1, 2'b01);
    recoverSeq(2'b01);

    phase = 2;
    faultAndRecover(2'b10, 2'b10, 2'b10);

`ifdef FAULT_COUNT_EN
    phase = 8;
    faultAndRecover(2'b01, 2'b10, 2'b10);
    for (int k = 0; k < 300; k++)
      faultAndRecover(2'b10, 2'b10, 2'b10);
`endif

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d expectations still queued, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "[TB] watchdog");
  end

endmodule
